cal_grid_draw: RTL and testbench

CAL_GRID_DRAW -- requirements
Module: cal_grid_draw

---
 rtl/cal_grid_draw_if.sv | 43 ++++
 rtl/cal_grid_draw.sv | 157 +++++++++++++++
 tb/tb_cal_grid_draw.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cal_grid_draw_if.sv
// Pixel stream, month snapshot inputs, font lookup and coloured pixel output
// of the calendar grid renderer. The slave modport is the renderer's view.
interface cal_grid_draw_if #(
    parameter int PIX_X_W = 12,
    parameter int PIX_Y_W = 12,
    parameter int GLYPH_W = 16,
    parameter int GLYPH_H = 32
);
    logic                       frame_start_i;
    logic                       pix_valid_i;
    logic [PIX_X_W-1:0]         pos_x_i;
    logic [PIX_Y_W-1:0]         pos_y_i;
    logic [2:0]                 month_first_day_i;
    logic [4:0]                 month_days_cnt_i;
    logic [4:0]                 day_in_month_i;
    logic [30:0]                alarm_day_mask_i;
    logic                       font_req_o;
    logic [3:0]                 font_char_o;
    logic [$clog2(GLYPH_H)-1:0] font_row_o;
    logic [$clog2(GLYPH_W)-1:0] font_col_o;
    logic                       font_bit_i;
    logic                       pix_valid_o;
    logic [2:0]                 pix_color_o;

    // Handshake: pix_valid_i qualifies pos_x_i/pos_y_i in the cycle it is high and
    // is always accepted (no ready); font_bit_i answers font_req_o one cycle later;
    // pix_valid_o qualifies pix_color_o exactly three cycles after acceptance.
    modport master (
        output frame_start_i, pix_valid_i, pos_x_i, pos_y_i,
        output month_first_day_i, month_days_cnt_i, day_in_month_i, alarm_day_mask_i,
        output font_bit_i,
        input  font_req_o, font_char_o, font_row_o, font_col_o,
        input  pix_valid_o, pix_color_o
    );

    modport slave (
        input  frame_start_i, pix_valid_i, pos_x_i, pos_y_i,
        input  month_first_day_i, month_days_cnt_i, day_in_month_i, alarm_day_mask_i,
        input  font_bit_i,
        output font_req_o, font_char_o, font_row_o, font_col_o,
        output pix_valid_o, pix_color_o
    );
endinterface

// File: rtl/cal_grid_draw.sv
// Month calendar grid renderer: classifies each pixel against a per-frame
// snapshot of the month and emits its colour with a fixed 3-cycle latency.
module cal_grid_draw #(
    parameter int          PIX_X_W       = 12,
    parameter int          PIX_Y_W       = 12,
    parameter int          GRID_X0       = 40,
    parameter int          GRID_Y0       = 120,
    parameter int          COLS          = 7,
    parameter int          ROWS          = 6,
    parameter int          CELL_W_LOG2   = 6,
    parameter int          CELL_H_LOG2   = 6,
    parameter int          GLYPH_W       = 16,
    parameter int          GLYPH_H       = 32,
    parameter int          TEXT_X0       = 8,
    parameter int          TEXT_Y0       = 16,
    parameter int          MARK_SZ       = 8,
    parameter int          BLINK_FRAMES  = 30,
    parameter logic [2:0]  FRAME_COLOR   = 3'b111,
    parameter logic [2:0]  BG_COLOR      = 3'b000,
    parameter logic [2:0]  TEXT_COLOR    = 3'b111,
    parameter logic [2:0]  WEEKEND_COLOR = 3'b101,
    parameter logic [2:0]  CUR_DAY_COLOR = 3'b101,
    parameter logic [2:0]  ALARM_COLOR   = 3'b100
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    cal_grid_draw_if.slave  bus
);
    localparam int FR_W   = $clog2(GLYPH_H);
    localparam int FC_W   = $clog2(GLYPH_W);
    localparam int BC_W   = $clog2(BLINK_FRAMES);
    localparam int CELL_W = 1 << CELL_W_LOG2;
    localparam int CELL_H = 1 << CELL_H_LOG2;

    logic            snap_valid;
    logic [2:0]      snap_first;
    logic [4:0]      snap_days;
    logic [4:0]      snap_today;
    logic [30:0]     snap_mask;
    logic [BC_W-1:0] blink_cnt;
    logic            blink_phase;

    logic            v1, v2;
    logic [2:0]      base1, base2, gcol1, gcol2;
    logic            req2;

    logic [PIX_X_W-1:0] dx, col_full;
    logic [PIX_Y_W-1:0] dy, row_full;
    int              cxi, cyi, day_i, tens, ones;
    logic            outside, in_month, frame, in_y, in_tens, in_ones, alarm, cur_day;
    logic            a_req;
    logic [3:0]      a_char;
    logic [FR_W-1:0] a_row;
    logic [FC_W-1:0] a_col;
    logic [2:0]      a_base, a_gcol;

    // Everything that depends on the snapshot is resolved here, at acceptance,
    // so a frame_start in the same cycle cannot affect this pixel.
    always_comb begin
        dx       = bus.pos_x_i - PIX_X_W'(GRID_X0);
        dy       = bus.pos_y_i - PIX_Y_W'(GRID_Y0);
        col_full = dx >> CELL_W_LOG2;
        row_full = dy >> CELL_H_LOG2;
        cxi      = int'(dx[CELL_W_LOG2-1:0]);
        cyi      = int'(dy[CELL_H_LOG2-1:0]);
        outside  = (int'(bus.pos_x_i) < GRID_X0) || (int'(bus.pos_y_i) < GRID_Y0) ||
                   (int'(col_full) >= COLS) || (int'(row_full) >= ROWS);
        day_i    = int'(row_full) * COLS + int'(col_full) - int'(snap_first) + 1;
        in_month = snap_valid && !outside && (day_i >= 1) && (day_i <= int'(snap_days));
        frame    = (cxi == 0) || (cyi == 0);
        tens     = 0;
        ones     = 0;
        if (in_month) begin
            tens = day_i / 10;
            ones = day_i % 10;
        end
        in_y     = (cyi >= TEXT_Y0) && (cyi < TEXT_Y0 + GLYPH_H);
        in_tens  = (cxi >= TEXT_X0) && (cxi < TEXT_X0 + GLYPH_W) && (tens != 0);
        in_ones  = (cxi >= TEXT_X0 + GLYPH_W) && (cxi < TEXT_X0 + 2 * GLYPH_W);
        a_req    = bus.pix_valid_i && in_month && !frame && in_y && (in_tens || in_ones);
        a_char   = 4'd0;
        a_row    = '0;
        a_col    = '0;
        if (a_req) begin
            a_char = in_tens ? 4'(tens) : 4'(ones);
            a_row  = FR_W'(cyi - TEXT_Y0);
            a_col  = in_tens ? FC_W'(cxi - TEXT_X0) : FC_W'(cxi - TEXT_X0 - GLYPH_W);
        end
        alarm    = in_month && snap_mask[5'(day_i - 1)] &&
                   (cxi >= CELL_W - 1 - MARK_SZ) && (cxi < CELL_W - 1) &&
                   (cyi >= CELL_H - 1 - MARK_SZ) && (cyi < CELL_H - 1);
        cur_day  = in_month && (day_i == int'(snap_today));
        // Colour used when the glyph bit turns out to be off.
        if (!snap_valid || outside) a_base = BG_COLOR;
        else if (frame)             a_base = FRAME_COLOR;
        else if (!in_month)         a_base = BG_COLOR;
        else if (alarm)             a_base = ALARM_COLOR;
        else if (cur_day && !blink_phase) a_base = CUR_DAY_COLOR;
        else                        a_base = BG_COLOR;
        a_gcol   = (int'(col_full) >= 5) ? WEEKEND_COLOR : TEXT_COLOR;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            snap_valid      <= 1'b0;
            snap_first      <= 3'd0;
            snap_days       <= 5'd0;
            snap_today      <= 5'd0;
            snap_mask       <= '0;
            blink_cnt       <= '0;
            blink_phase     <= 1'b0;
            v1              <= 1'b0;
            v2              <= 1'b0;
            base1           <= BG_COLOR;
            base2           <= BG_COLOR;
            gcol1           <= BG_COLOR;
            gcol2           <= BG_COLOR;
            req2            <= 1'b0;
            bus.font_req_o  <= 1'b0;
            bus.font_char_o <= 4'd0;
            bus.font_row_o  <= '0;
            bus.font_col_o  <= '0;
            bus.pix_valid_o <= 1'b0;
            bus.pix_color_o <= BG_COLOR;
        end else begin
            if (bus.frame_start_i) begin
                snap_valid <= (bus.month_first_day_i <= 3'd6) &&
                              (bus.month_days_cnt_i >= 5'd28);
                snap_first <= bus.month_first_day_i;
                snap_days  <= bus.month_days_cnt_i;
                snap_today <= bus.day_in_month_i;
                snap_mask  <= bus.alarm_day_mask_i;
                if (int'(blink_cnt) == BLINK_FRAMES - 1) begin
                    blink_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    blink_cnt   <= blink_cnt + 1'b1;
                end
            end
            v1              <= bus.pix_valid_i;
            base1           <= a_base;
            gcol1           <= a_gcol;
            bus.font_req_o  <= a_req;
            bus.font_char_o <= a_char;
            bus.font_row_o  <= a_row;
            bus.font_col_o  <= a_col;
            v2              <= v1;
            base2           <= base1;
            gcol2           <= gcol1;
            req2            <= bus.font_req_o;
            bus.pix_valid_o <= v2;
            if (!v2)                          bus.pix_color_o <= BG_COLOR;
            else if (req2 && bus.font_bit_i)  bus.pix_color_o <= gcol2;
            else                              bus.pix_color_o <= base2;
        end
    end
endmodule

// File: tb/tb_cal_grid_draw.sv
// Directed bench for cal_grid_draw: hand-computed pixels around the calendar grid,
// font lookups, blink, snapshot timing and reset behaviour.
module tb_cal_grid_draw;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cal_grid_draw_if bus ();

    cal_grid_draw dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_month(input int first, input int days, input int today, input logic [30:0] mask);
        bus.month_first_day_i = 3'(first);
        bus.month_days_cnt_i  = 5'(days);
        bus.day_in_month_i    = 5'(today);
        bus.alarm_day_mask_i  = mask;
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        bus.frame_start_i = 1'b1;
        @(negedge clk);
        bus.frame_start_i = 1'b0;
    endtask

    // Accept one pixel (optionally with frame_start), answer the font lookup with fb,
    // and check the font request at n+1 and the colour at n+3.
    task automatic pixel(input string tag, input int x, input int y, input logic fs,
                         input logic fb, input logic er, input int ec, input int erow,
                         input int ecol, input logic [2:0] ecolor);
        @(negedge clk);
        bus.pix_valid_i   = 1'b1;
        bus.frame_start_i = fs;
        bus.pos_x_i       = 12'(x);
        bus.pos_y_i       = 12'(y);
        @(negedge clk);
        bus.pix_valid_i   = 1'b0;
        bus.frame_start_i = 1'b0;
        chk({tag, "_req"},  32'(bus.font_req_o),  32'(er));
        chk({tag, "_char"}, 32'(bus.font_char_o), 32'(ec));
        chk({tag, "_row"},  32'(bus.font_row_o),  32'(erow));
        chk({tag, "_col"},  32'(bus.font_col_o),  32'(ecol));
        bus.font_bit_i = fb;
        @(negedge clk);
        chk({tag, "_early"}, 32'(bus.pix_valid_o), 32'd0);
        @(negedge clk);
        bus.font_bit_i = 1'b0;
        chk({tag, "_valid"}, 32'(bus.pix_valid_o), 32'd1);
        chk({tag, "_color"}, 32'(bus.pix_color_o), 32'(ecolor));
        @(negedge clk);
        chk({tag, "_bubble"}, 32'(bus.pix_valid_o), 32'd0);
    endtask

    initial begin
        bus.frame_start_i = 1'b0;
        bus.pix_valid_i   = 1'b0;
        bus.pos_x_i       = '0;
        bus.pos_y_i       = '0;
        bus.font_bit_i    = 1'b0;
        set_month(0, 0, 0, '0);

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.pix_valid_o), 32'd0);
        chk("rst_color", 32'(bus.pix_color_o), 32'd0);
        chk("rst_req",   32'(bus.font_req_o),  32'd0);
        chk("rst_char",  32'(bus.font_char_o), 32'd0);
        rst_n = 1'b1;

        // No snapshot yet: whole screen is background.
        pixel("nosnap", 200, 200, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3'b000);

        // Month starts on Wednesday, 31 days, today = 1, alarm on day 1.
        set_month(2, 31, 1, 31'h1);
        frame_pulse();                                                     // pulse 1
        pixel("d1_glyph",  192, 136, 1'b0, 1'b1, 1'b1, 1, 0, 0, 3'b111);
        pixel("d1_noglyph",192, 136, 1'b0, 1'b0, 1'b1, 1, 0, 0, 3'b101);
        pixel("frame",      40, 150, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b111);
        pixel("day_neg",    60, 150, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3'b000);
        pixel("alarm",     223, 175, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b100);
        pixel("cur_fill",  200, 170, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b101);
        // Day 12 in Sunday column: tens glyph '1', weekend colour.
        pixel("wkend_tens",434, 204, 1'b0, 1'b1, 1'b1, 1, 4, 2, 3'b101);
        // Day 5: tens box suppressed.
        pixel("tens_sup",  434, 140, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3'b000);
        pixel("left_out",   39, 200, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3'b000);
        pixel("col7_out",  488, 200, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3'b000);
        pixel("row6_out",  100, 504, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3'b000);

        // 30 more frames: the 30th pulse wraps the counter and flips the blink phase.
        for (int i = 0; i < 30; i++) frame_pulse();                        // pulses 2..31
        pixel("blink_off", 200, 170, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);

        // frame_start coincident with the pixel: day 30 still in month (31 days).
        set_month(2, 28, 1, 31'h1);
        pixel("coinc_old", 242, 396, 1'b1, 1'b1, 1'b1, 3, 4, 2, 3'b111);
        pixel("coinc_new", 242, 396, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3'b000);

        // 27 days is not a legal month: grid blanks, frame lines included.
        set_month(2, 27, 1, 31'h1);
        frame_pulse();
        pixel("bad_days",   40, 150, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);

        // Reset while a pixel is in flight: it must never appear.
        set_month(2, 31, 1, 31'h1);
        frame_pulse();
        pixel("pre_rst",    40, 150, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b111);
        @(negedge clk);
        bus.pix_valid_i = 1'b1;
        bus.pos_x_i     = 12'd40;
        bus.pos_y_i     = 12'd150;
        @(negedge clk);
        bus.pix_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.pix_valid_o), 32'd0);
        chk("midrst_req",   32'(bus.font_req_o),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_drop", 32'(bus.pix_valid_o), 32'd0);
        end
        // Snapshot was cleared by reset: background until the next frame_start.
        pixel("post_rst",   40, 150, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
